// File: rtl/uriscv_irq_ctrl.sv
// uriscv_irq_ctrl: interrupt aggregator in front of the CPU trap unit.
// Synchronises raw request lines, latches edge/level pending state, picks the
// lowest-index enabled pending source and exposes a small register port for
// enable, trigger mode, claim and complete (one source in service at a time).
//
// Register port handshake: reg_valid_i is always accepted on the rising edge
// it is sampled high; writes take effect on that edge; reads return data on
// reg_rdata_o together with a one-cycle reg_rvalid_o pulse on the next cycle.
module uriscv_irq_ctrl #(
    parameter int unsigned NUM_IRQS     = 8,
    parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
    parameter int unsigned VECTOR_SHIFT = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_IRQS-1:0] irq_i,
    output logic                intr_o,
    output logic [31:0]         isr_vector_o,
    input  logic                reg_valid_i,
    input  logic                reg_write_i,
    input  logic [4:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_rvalid_o
);

    localparam logic [2:0] WORD_PENDING  = 3'd0;
    localparam logic [2:0] WORD_ENABLE   = 3'd1;
    localparam logic [2:0] WORD_EDGE     = 3'd2;
    localparam logic [2:0] WORD_CLAIM    = 3'd3;
    localparam logic [2:0] WORD_COMPLETE = 3'd4;

    typedef logic [NUM_IRQS-1:0] irq_vec_t;

    irq_vec_t    sync1_q, sync1_d;
    irq_vec_t    sync2_q, sync2_d;
    irq_vec_t    prev_q, prev_d;
    irq_vec_t    pending_q, pending_d;
    irq_vec_t    enable_q, enable_d;
    irq_vec_t    edge_q, edge_d;
    logic [4:0]  in_service_q, in_service_d;
    logic        in_service_valid_q, in_service_valid_d;
    logic        intr_q, intr_d;
    logic [31:0] isr_vector_q, isr_vector_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    irq_vec_t    active;
    irq_vec_t    rise;
    irq_vec_t    claim_clr;
    logic        win_found;
    logic [4:0]  win_idx;
    logic [2:0]  word;
    logic        rd_strobe;
    logic        wr_strobe;
    logic        claim_hit;
    logic        complete_hit;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^reg_addr_i[1:0];

    assign word      = reg_addr_i[4:2];
    assign rd_strobe = reg_valid_i & ~reg_write_i;
    assign wr_strobe = reg_valid_i & reg_write_i;

    // Lowest-index enabled pending source wins.
    always_comb begin
        active    = pending_q & enable_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = int'(NUM_IRQS) - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_found = 1'b1;
                win_idx   = 5'(i);
            end
        end
    end

    // Next state of synchronisers, pending, control registers and outputs.
    always_comb begin
        sync1_d            = irq_i;
        sync2_d            = sync1_q;
        prev_d             = sync2_q;
        rise               = sync2_q & ~prev_q;
        enable_d           = enable_q;
        edge_d             = edge_q;
        in_service_d       = in_service_q;
        in_service_valid_d = in_service_valid_q;
        rdata_d            = rdata_q;
        rvalid_d           = rd_strobe;

        // A claim only succeeds when nothing is already in service.
        claim_hit    = rd_strobe && (word == WORD_CLAIM) && win_found && !in_service_valid_q;
        claim_clr    = claim_hit ? (irq_vec_t'(1) << win_idx) : '0;
        complete_hit = wr_strobe && (word == WORD_COMPLETE) && in_service_valid_q &&
                       (reg_wdata_i == (32'(in_service_q) + 32'd1));

        // Edge sources: a rise in the claim cycle wins over the claim clear.
        // Level sources simply track the synchronised line.
        pending_d = (edge_q & ((pending_q & ~claim_clr) | rise)) | (~edge_q & sync2_q);

        if (wr_strobe && (word == WORD_ENABLE)) begin
            enable_d = reg_wdata_i[NUM_IRQS-1:0];
        end
        if (wr_strobe && (word == WORD_EDGE)) begin
            edge_d = reg_wdata_i[NUM_IRQS-1:0];
        end

        if (claim_hit) begin
            in_service_d       = win_idx;
            in_service_valid_d = 1'b1;
        end else if (complete_hit) begin
            in_service_valid_d = 1'b0;
        end

        if (rd_strobe) begin
            case (word)
                WORD_PENDING:  rdata_d = 32'(pending_q);
                WORD_ENABLE:   rdata_d = 32'(enable_q);
                WORD_EDGE:     rdata_d = 32'(edge_q);
                WORD_CLAIM:    rdata_d = claim_hit ? (32'(win_idx) + 32'd1) : 32'd0;
                WORD_COMPLETE: rdata_d = in_service_valid_q ? (32'(in_service_q) + 32'd1) : 32'd0;
                default:       rdata_d = 32'd0;
            endcase
        end

        intr_d       = (|active) & ~in_service_valid_q;
        isr_vector_d = win_found ? (VECTOR_BASE + (32'(win_idx) << VECTOR_SHIFT)) : isr_vector_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q            <= '0;
            sync2_q            <= '0;
            prev_q             <= '0;
            pending_q          <= '0;
            enable_q           <= '0;
            edge_q             <= '0;
            in_service_q       <= '0;
            in_service_valid_q <= 1'b0;
            intr_q             <= 1'b0;
            isr_vector_q       <= VECTOR_BASE;
            rdata_q            <= '0;
            rvalid_q           <= 1'b0;
        end else begin
            sync1_q            <= sync1_d;
            sync2_q            <= sync2_d;
            prev_q             <= prev_d;
            pending_q          <= pending_d;
            enable_q           <= enable_d;
            edge_q             <= edge_d;
            in_service_q       <= in_service_d;
            in_service_valid_q <= in_service_valid_d;
            intr_q             <= intr_d;
            isr_vector_q       <= isr_vector_d;
            rdata_q            <= rdata_d;
            rvalid_q           <= rvalid_d;
        end
    end

    assign intr_o       = intr_q;
    assign isr_vector_o = isr_vector_q;
    assign reg_rdata_o  = rdata_q;
    assign reg_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_uriscv_irq_ctrl.sv
// Self-checking bench for uriscv_irq_ctrl: register table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_uriscv_irq_ctrl;

    localparam int N = 8;
    localparam logic [31:0] VBASE = 32'h0000_0100;

    localparam logic [4:0] A_PEND  = 5'h00;
    localparam logic [4:0] A_EN    = 5'h04;
    localparam logic [4:0] A_EDGE  = 5'h08;
    localparam logic [4:0] A_CLAIM = 5'h0C;
    localparam logic [4:0] A_COMPL = 5'h10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_i = '0;
    logic          intr_o;
    logic [31:0]   isr_vector_o;
    logic          reg_valid = 1'b0;
    logic          reg_write = 1'b0;
    logic [4:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata_o;
    logic          reg_rvalid_o;

    int checks = 0;
    int failures = 0;

    // Clock and DUT.
    always #5 clk = ~clk;

    uriscv_irq_ctrl #(.NUM_IRQS(N), .VECTOR_BASE(VBASE), .VECTOR_SHIFT(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_i        (irq_i),
        .intr_o       (intr_o),
        .isr_vector_o (isr_vector_o),
        .reg_valid_i  (reg_valid),
        .reg_write_i  (reg_write),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_rdata_o  (reg_rdata_o),
        .reg_rvalid_o (reg_rvalid_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        irq_i = '0;
        reg_valid = 1'b0;
        reg_write = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_valid = 1'b1;
        reg_write = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_valid = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_valid = 1'b1;
        reg_write = 1'b0;
        reg_addr  = a;
        @(negedge clk);
        reg_valid = 1'b0;
        d = reg_rdata_o;
        check("rvalid", {31'd0, reg_rvalid_o}, 32'd1);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_rd(a, d);
        check(name, d, exp);
    endtask

    // Transaction-level reference model.
    logic [N-1:0] m_pend, m_en, m_edge, m_irq;
    logic         m_isv;
    int           m_is;
    logic [31:0]  m_vec;

    function automatic int m_winner();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i]) return i;
        return -1;
    endfunction

    function automatic void m_settle();
        int w;
        for (int i = 0; i < N; i++)
            if (!m_edge[i]) m_pend[i] = m_irq[i];
        w = m_winner();
        if (w >= 0) m_vec = VBASE + 32'(w * 4);
    endfunction

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] d;
        int w;
        int op;
        logic [31:0] exp_v;

        tbl[0]  = '{1'b0, 5'h00, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 5'h04, 32'h0,         32'h0};
        tbl[2]  = '{1'b0, 5'h08, 32'h0,         32'h0};
        tbl[3]  = '{1'b0, 5'h0C, 32'h0,         32'h0};
        tbl[4]  = '{1'b0, 5'h10, 32'h0,         32'h0};
        tbl[5]  = '{1'b1, 5'h04, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b0, 5'h04, 32'h0,         32'h0000_00FF};
        tbl[7]  = '{1'b1, 5'h08, 32'hA5A5_A5A5, 32'h0};
        tbl[8]  = '{1'b0, 5'h08, 32'h0,         32'h0000_00A5};
        tbl[9]  = '{1'b0, 5'h0B, 32'h0,         32'h0000_00A5};
        tbl[10] = '{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{1'b0, 5'h00, 32'h0,         32'h0};
        tbl[12] = '{1'b0, 5'h14, 32'h0,         32'h0};
        tbl[13] = '{1'b0, 5'h1C, 32'h0,         32'h0};
        tbl[14] = '{1'b1, 5'h04, 32'h0,         32'h0};
        tbl[15] = '{1'b1, 5'h08, 32'h0,         32'h0};
        tbl[16] = '{1'b0, 5'h04, 32'h0,         32'h0};

        // Reset state.
        cyc(2);
        check("reset_intr", {31'd0, intr_o}, 32'd0);
        check("reset_vector", isr_vector_o, VBASE);
        check("reset_rdata", reg_rdata_o, 32'd0);
        check("reset_rvalid", {31'd0, reg_rvalid_o}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Register table.
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) reg_wr(tbl[i].addr, tbl[i].data);
            else rd_chk($sformatf("table_%0d", i), tbl[i].addr, tbl[i].exp);
        end

        // Basic edge flow with exact latency.
        apply_reset();
        reg_wr(A_EN, 32'h01);
        reg_wr(A_EDGE, 32'h01);
        irq_i[0] = 1'b1;
        cyc(3);
        check("edge_intr_early", {31'd0, intr_o}, 32'd0);
        irq_i[0] = 1'b0;
        cyc(1);
        check("edge_intr_e3", {31'd0, intr_o}, 32'd1);
        check("edge_vector", isr_vector_o, 32'h100);
        rd_chk("edge_claim", A_CLAIM, 32'd1);
        cyc(1);
        check("edge_intr_drop", {31'd0, intr_o}, 32'd0);
        rd_chk("edge_pending", A_PEND, 32'd0);

        // Priority.
        apply_reset();
        reg_wr(A_EN, 32'hFF);
        reg_wr(A_EDGE, 32'hFF);
        irq_i = 8'h24;
        cyc(5);
        check("prio_vector", isr_vector_o, 32'h108);
        check("prio_intr", {31'd0, intr_o}, 32'd1);
        rd_chk("prio_claim2", A_CLAIM, 32'd3);
        reg_wr(A_COMPL, 32'd3);
        cyc(2);
        check("prio_intr_again", {31'd0, intr_o}, 32'd1);
        check("prio_vector5", isr_vector_o, 32'h114);
        rd_chk("prio_claim5", A_CLAIM, 32'd6);

        // Level mode.
        apply_reset();
        irq_i[1] = 1'b1;
        reg_wr(A_EN, 32'h02);
        cyc(4);
        rd_chk("level_claim", A_CLAIM, 32'd2);
        cyc(2);
        check("level_intr_in_service", {31'd0, intr_o}, 32'd0);
        reg_wr(A_COMPL, 32'd2);
        cyc(2);
        check("level_intr_after_complete", {31'd0, intr_o}, 32'd1);
        irq_i[1] = 1'b0;
        cyc(4);
        check("level_intr_drop", {31'd0, intr_o}, 32'd0);

        // Masking and guards.
        apply_reset();
        reg_wr(A_EDGE, 32'h01);
        irq_i[0] = 1'b1;
        cyc(5);
        irq_i[0] = 1'b0;
        check("mask_intr", {31'd0, intr_o}, 32'd0);
        rd_chk("mask_pending", A_PEND, 32'd1);
        rd_chk("mask_claim", A_CLAIM, 32'd0);
        reg_wr(A_EN, 32'h01);
        cyc(2);
        check("unmask_intr", {31'd0, intr_o}, 32'd1);
        rd_chk("guard_claim", A_CLAIM, 32'd1);
        rd_chk("guard_claim_again", A_CLAIM, 32'd0);
        reg_wr(A_COMPL, 32'd2);
        rd_chk("guard_wrong_complete", A_COMPL, 32'd1);
        reg_wr(A_EN, 32'h00);
        rd_chk("guard_disable_keeps", A_COMPL, 32'd1);
        reg_wr(A_COMPL, 32'd1);
        rd_chk("guard_completed", A_COMPL, 32'd0);

        // Race: rise of source 0 on the same edge as its claim.
        apply_reset();
        reg_wr(A_EN, 32'h01);
        reg_wr(A_EDGE, 32'h01);
        irq_i[0] = 1'b1;
        cyc(5);
        irq_i[0] = 1'b0;
        cyc(4);
        irq_i[0] = 1'b1;
        cyc(2);
        reg_valid = 1'b1;
        reg_write = 1'b0;
        reg_addr  = A_CLAIM;
        cyc(1);
        reg_valid = 1'b0;
        check("race_claim", reg_rdata_o, 32'd1);
        rd_chk("race_pending", A_PEND, 32'd1);
        reg_wr(A_COMPL, 32'd1);
        cyc(2);
        check("race_intr", {31'd0, intr_o}, 32'd1);

        // Asynchronous reset in the middle of service.
        apply_reset();
        reg_wr(A_EN, 32'h18);
        reg_wr(A_EDGE, 32'h18);
        irq_i = 8'h18;
        cyc(5);
        rd_chk("areset_claim", A_CLAIM, 32'd4);
        check("areset_vec_before", isr_vector_o, 32'h10C);
        #2;
        rst_n = 1'b0;
        irq_i = '0;
        #1;
        check("areset_intr", {31'd0, intr_o}, 32'd0);
        check("areset_vector", isr_vector_o, VBASE);
        check("areset_rdata", reg_rdata_o, 32'd0);
        check("areset_rvalid", {31'd0, reg_rvalid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        rd_chk("areset_pend", A_PEND, 32'd0);
        rd_chk("areset_en", A_EN, 32'd0);
        rd_chk("areset_edge", A_EDGE, 32'd0);
        rd_chk("areset_compl", A_COMPL, 32'd0);

        // Randomized run against the model.
        apply_reset();
        m_pend = '0; m_en = '0; m_edge = '0; m_irq = '0;
        m_isv = 1'b0; m_is = 0; m_vec = VBASE;
        for (int it = 0; it < 120; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    d = 32'($urandom_range(0, 255));
                    for (int i = 0; i < N; i++)
                        if (m_edge[i] && d[i] && !m_irq[i]) m_pend[i] = 1'b1;
                    m_irq = d[N-1:0];
                    irq_i = d[N-1:0];
                end
                1: begin
                    d = $urandom;
                    reg_wr(A_EN, d);
                    m_en = d[N-1:0];
                end
                2: begin
                    d = $urandom;
                    reg_wr(A_EDGE, d);
                    m_edge = d[N-1:0];
                end
                3: begin
                    w = m_winner();
                    exp_v = 32'd0;
                    if (w >= 0 && !m_isv) begin
                        exp_v = 32'(w + 1);
                        m_isv = 1'b1;
                        m_is = w;
                        if (m_edge[w]) m_pend[w] = 1'b0;
                    end
                    rd_chk("rand_claim", A_CLAIM, exp_v);
                end
                4: begin
                    if (m_isv && $urandom_range(0, 1) == 1) d = 32'(m_is + 1);
                    else d = 32'($urandom_range(0, 9));
                    reg_wr(A_COMPL, d);
                    if (m_isv && d == 32'(m_is + 1)) m_isv = 1'b0;
                end
                default: rd_chk("rand_pending", A_PEND, 32'(m_pend));
            endcase
            m_settle();
            cyc(5);
            check("rand_intr", {31'd0, intr_o}, {31'd0, ((m_pend & m_en) != '0) && !m_isv});
            check("rand_vector", isr_vector_o, m_vec);
            rd_chk("rand_complete", A_COMPL, m_isv ? 32'(m_is + 1) : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
